// File: rtl/log_capture_pkg.sv
// Shared definitions for the capture controller.
// Contents: the capture FSM state type, the capture mode encodings, the
// default address width, and a helper that tells whether a state is
// actively capturing.
package log_capture_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } cap_state_e;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_TRIG   = 1'b1;

  localparam int DEF_RAM_DEPTH = 32768;
  localparam int ADDR_W        = $clog2(DEF_RAM_DEPTH);

  // True in the states where sample strobes may be written.
  function automatic logic is_capture(input cap_state_e s);
    return (s == FILL) || (s == WAIT_TRIG) || (s == POST);
  endfunction

endpackage

// File: rtl/log_capture_block_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// Ports:
//   clk              clock
//   reset            synchronous active-high reset (read register only)
//   wr_en/addr/data  write port
//   rd_en            load the read register from mem[rd_addr]
//   rd_clr           force the read register to zero (wins over rd_en)
//   rd_addr          read address
//   rd_data          read data: 1 cycle after rd_en for LOW_LATENCY,
//                    2 cycles for HIGH_PERFORMANCE
// Memory contents are never reset so the array maps onto block RAM.
module block_ram #(
  parameter int    WIDTH           = 32,
  parameter int    DEPTH           = 1024,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] q_r;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when neither enable nor clear is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {WIDTH{1'b0}};
    end else if (rd_clr) begin
      q_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      q_r <= mem_r[rd_addr];
    end
  end

  generate
    if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_hp
      logic [WIDTH-1:0] q2_r;
      logic             upd_r;

      // Extra output stage, updated only when the first stage was just loaded.
      always_ff @(posedge clk) begin
        if (reset) begin
          q2_r  <= {WIDTH{1'b0}};
          upd_r <= 1'b0;
        end else begin
          upd_r <= rd_en | rd_clr;
          if (upd_r) begin
            q2_r <= q_r;
          end
        end
      end

      assign rd_data = q2_r;
    end else begin : g_ll
      assign rd_data = q_r;
    end
  endgenerate

endmodule

// File: rtl/log_capture_ctrl.sv
// Capture engine: logs one of N_CHAN sample streams into a block RAM, either
// as a linear one-shot or as a triggered circular capture with a pre-trigger
// window, with optional decimation. Readout is in chronological order.
// Ports:
//   clk, i_reset          clock, synchronous active-high reset
//   i_start, i_mode       arm pulse and capture mode (0 linear, 1 triggered)
//   i_chan_sel, i_decim   channel and decimation, latched on accepted start
//   i_data, i_valid       packed channel samples and per-channel strobes
//   i_trigger             level trigger, looked at in WAIT_TRIG only
//   i_rd_en, i_rd_addr    read request, logical index (0 = oldest)
//   o_rd_data             read data, 1-cycle latency, 0 if read while busy
//   o_busy, o_done        capture in progress / buffer complete
//   o_trig_addr           physical address of first post-trigger sample
module log_capture_ctrl
  import log_capture_pkg::*;
#(
  parameter int N_CHAN    = 4,
  parameter int NB_DATA   = 24,
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32768,
  parameter int PRE_TRIG  = 1024,
  parameter int NB_DECIM  = 8
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_mode,
  input  logic [$clog2(N_CHAN)-1:0]    i_chan_sel,
  input  logic [NB_DECIM-1:0]          i_decim,
  input  logic [N_CHAN*NB_DATA-1:0]    i_data,
  input  logic [N_CHAN-1:0]            i_valid,
  input  logic                         i_trigger,
  input  logic                         i_rd_en,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_rd_addr,
  output logic [RAM_WIDTH-1:0]         o_rd_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(RAM_DEPTH)-1:0] o_trig_addr
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(N_CHAN);

  // Last count value of each phase; the counter is one bit wider than the
  // address so a full linear capture of RAM_DEPTH writes is representable.
  localparam logic [AW:0]   FILL_LAST     = (AW+1)'(PRE_TRIG - 1);
  localparam logic [AW:0]   POST_LAST_LIN = (AW+1)'(RAM_DEPTH - 1);
  localparam logic [AW:0]   POST_LAST_TRG = (AW+1)'(RAM_DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] PRE_A         = AW'(PRE_TRIG);

  cap_state_e            state_r, state_nx_s;
  logic                  mode_r;
  logic [CW-1:0]         chan_r;
  logic [NB_DECIM-1:0]   decim_r;
  logic [NB_DECIM-1:0]   decim_cnt_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW:0]           cnt_r;
  logic [AW-1:0]         trig_addr_r;
  logic                  busy_r, done_r;

  logic                  start_acc_s, trig_hit_s, fill_end_s;
  logic                  strobe_s, wr_en_s;
  logic [AW:0]           post_last_s;
  logic signed [NB_DATA-1:0] sample_s;
  logic [RAM_WIDTH-1:0]  wr_data_s;
  logic [AW-1:0]         start_addr_s, rd_addr_s;
  logic                  rd_ok_s, ram_rd_en_s, ram_rd_clr_s;

  assign strobe_s    = is_capture(state_r) && i_valid[chan_r];
  assign wr_en_s     = strobe_s && (decim_cnt_r == {NB_DECIM{1'b0}});
  assign post_last_s = (mode_r == MODE_TRIG) ? POST_LAST_TRG : POST_LAST_LIN;

  assign sample_s  = i_data[chan_r*NB_DATA +: NB_DATA];
  assign wr_data_s = RAM_WIDTH'(sample_s);

  // Oldest sample sits PRE_TRIG writes before the trigger point (mod depth).
  assign start_addr_s = (mode_r == MODE_TRIG) ? (trig_addr_r - PRE_A) : {AW{1'b0}};
  assign rd_addr_s    = start_addr_s + i_rd_addr;

  // A start in the same cycle as a read takes priority and the read yields 0.
  assign rd_ok_s      = ((state_r == IDLE) || (state_r == DONE)) && !i_start;
  assign ram_rd_en_s  = i_rd_en && rd_ok_s;
  assign ram_rd_clr_s = i_rd_en && !rd_ok_s;

  // Next-state logic and phase events.
  always_comb begin
    state_nx_s  = state_r;
    start_acc_s = 1'b0;
    trig_hit_s  = 1'b0;
    fill_end_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (i_start) begin
          start_acc_s = 1'b1;
          state_nx_s  = (i_mode == MODE_TRIG) ? FILL : POST;
        end else begin
          state_nx_s = state_r;
        end
      end
      FILL: begin
        if (wr_en_s && (cnt_r == FILL_LAST)) begin
          fill_end_s = 1'b1;
          state_nx_s = WAIT_TRIG;
        end else begin
          state_nx_s = FILL;
        end
      end
      WAIT_TRIG: begin
        if (i_trigger) begin
          trig_hit_s = 1'b1;
          // The write in the trigger cycle is already post-sample #1.
          if (wr_en_s && (POST_LAST_TRG == {(AW+1){1'b0}})) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = POST;
          end
        end else begin
          state_nx_s = WAIT_TRIG;
        end
      end
      POST: begin
        if (wr_en_s && (cnt_r == post_last_s)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = POST;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register and registered status flags.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= is_capture(state_nx_s);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Capture datapath: latched configuration, pointer, counters, trigger address.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      mode_r      <= MODE_LINEAR;
      chan_r      <= {CW{1'b0}};
      decim_r     <= {NB_DECIM{1'b0}};
      decim_cnt_r <= {NB_DECIM{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      cnt_r       <= {(AW+1){1'b0}};
      trig_addr_r <= {AW{1'b0}};
    end else if (start_acc_s) begin
      mode_r      <= i_mode;
      chan_r      <= i_chan_sel;
      decim_r     <= i_decim;
      decim_cnt_r <= {NB_DECIM{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      cnt_r       <= {(AW+1){1'b0}};
    end else begin
      if (strobe_s) begin
        decim_cnt_r <= (decim_cnt_r == decim_r) ? {NB_DECIM{1'b0}}
                                                : decim_cnt_r + NB_DECIM'(1);
      end
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      // cnt_r counts pre-trigger writes in FILL and post-trigger writes in POST.
      if (fill_end_s) begin
        cnt_r <= {(AW+1){1'b0}};
      end else if (trig_hit_s) begin
        cnt_r <= wr_en_s ? (AW+1)'(1) : {(AW+1){1'b0}};
      end else if (wr_en_s) begin
        cnt_r <= cnt_r + (AW+1)'(1);
      end
      if (trig_hit_s) begin
        trig_addr_r <= wr_ptr_r;
      end
    end
  end

  block_ram #(
    .WIDTH          (RAM_WIDTH),
    .DEPTH          (RAM_DEPTH),
    .RAM_PERFORMANCE("LOW_LATENCY")
  ) u_ram (
    .clk    (clk),
    .reset  (i_reset),
    .wr_en  (wr_en_s),
    .wr_addr(wr_ptr_r),
    .wr_data(wr_data_s),
    .rd_en  (ram_rd_en_s),
    .rd_clr (ram_rd_clr_s),
    .rd_addr(rd_addr_s),
    .rd_data(o_rd_data)
  );

  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_trig_addr = trig_addr_r;

endmodule

// File: doc/log_capture_ctrl.md
Name: log_capture_ctrl

Overview:
Parametrised capture engine that records one of N_CHAN sample streams into an internal block RAM for offline readout of equalizer taps, slicer input, FSE output and similar signals. It supports linear one-shot capture and triggered circular capture with a programmable pre-trigger window, plus per-capture decimation. It sits between the DSP datapath and the host read interface and returns the buffer in chronological order, independent of where the trigger landed.

Parameters:
N_CHAN, 4, number of selectable input channels
NB_DATA, 24, width of each channel sample
RAM_WIDTH, 32, RAM word width; NB_DATA <= RAM_WIDTH
RAM_DEPTH, 32768, words; power of two
PRE_TRIG, 1024, samples kept before trigger in triggered mode; 0 < PRE_TRIG < RAM_DEPTH
NB_DECIM, 8, width of decimation factor

Ports:
clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_start  in  1  arm pulse; accepted only in IDLE or DONE
i_mode  in  1  0 = linear one-shot, 1 = triggered circular
i_chan_sel  in  $clog2(N_CHAN)  channel to log; latched on accepted i_start
i_decim  in  NB_DECIM  keep 1 of every (i_decim+1) strobes; latched on i_start
i_data  in  N_CHAN*NB_DATA  packed channel samples; channel c at [(c+1)*NB_DATA-1 -: NB_DATA]
i_valid  in  N_CHAN  per-channel sample strobes (rate enables)
i_trigger  in  1  level trigger, sampled in WAIT_TRIG only
i_rd_en  in  1  read request
i_rd_addr  in  $clog2(RAM_DEPTH)  logical read index, 0 = oldest sample
o_rd_data  out  RAM_WIDTH  read data, 1-cycle latency
o_busy  out  1  capture in progress (FILL/WAIT_TRIG/POST)
o_done  out  1  buffer complete and readable
o_trig_addr  out  $clog2(RAM_DEPTH)  physical address of first post-trigger sample

Behaviour:
- Reset: state IDLE. o_rd_data=0, o_busy=0, o_done=0, o_trig_addr=0. Write pointer, sample counter and decimation counter are 0.
- FSM states: IDLE, FILL, WAIT_TRIG, POST, DONE.
  - IDLE/DONE + i_start: latch mode, channel and decim; clear pointer and counters; clear o_done. Go to POST if mode=0, FILL if mode=1.
  - FILL -> WAIT_TRIG once PRE_TRIG samples have been written.
  - WAIT_TRIG -> POST on the first cycle with i_trigger=1.
  - POST -> DONE once the post count reaches its target: RAM_DEPTH for mode 0, RAM_DEPTH-PRE_TRIG for mode 1.
- Write qualifier: i_valid[sel] && decim_cnt==0 while in FILL/WAIT_TRIG/POST.
  - decim_cnt counts qualified-channel strobes modulo (decim+1).
  - Strobes on unselected channels are ignored.
- Write data: selected sample sign-extended to RAM_WIDTH.
- Write address: the pointer increments modulo RAM_DEPTH on each write.
  - Mode 0 fills addresses 0..DEPTH-1 with no wrap.
  - Mode 1 wraps freely during WAIT_TRIG.
- i_trigger during FILL is ignored; this guarantees a full pre-trigger window.
- Trigger cycle: o_trig_addr is loaded with the current write pointer. A write occurring in the same cycle is post-sample #1 and counts toward the target.
- Oldest sample: start_addr = 0 for mode 0; (o_trig_addr - PRE_TRIG) mod RAM_DEPTH for mode 1.
- Read path:
  - Physical address = (start_addr + i_rd_addr) mod RAM_DEPTH.
  - o_rd_data is registered and valid one cycle after i_rd_en.
  - Reads are honoured only in IDLE/DONE. A read while o_busy=1 returns 0.
  - o_rd_data holds its value when i_rd_en=0.
- o_busy/o_done are registered outputs of the FSM. o_done rises the cycle after the final write.
- i_start in FILL/WAIT_TRIG/POST is ignored. Selection and decim changes mid-capture are ignored.
- i_reset mid-capture: return to reset values on the next edge. RAM contents are not cleared.
- Simultaneous i_start and i_rd_en in DONE: start wins, and the read returns 0.

Decomposition:
- Shared package log_capture_pkg holds:
  - state enum: IDLE, FILL, WAIT_TRIG, POST, DONE
  - MODE_LINEAR=0, MODE_TRIG=1
  - localparam ADDR_W = $clog2(RAM_DEPTH)
- One sub-module: block_ram, a simple dual-port RAM with write port and registered read port, instantiated with RAM_PERFORMANCE="LOW_LATENCY".

Test Plan:
1. Linear capture. Test params: DEPTH=16, PRE_TRIG=4, N_CHAN=4, NB_DATA=12, RAM_WIDTH=16. Stimulus: mode 0, chan 2, decim 0, i_valid[2] every cycle, ramp 0,1,2... Required: o_busy for 16 writes; o_done=1 the cycle after the 16th write; reading addr k returns k.
2. Decimation. decim=2 and ramp data on chan 1. Required: stored values are 0,3,6,...,45; o_done after 46 strobes.
3. Triggered capture. mode 1; trigger pulsed after 2 samples (ignored); trigger held high while ramp value 10 is written. Required: o_trig_addr=10; readout 0..15 returns 6..21.
4. Triggered wrap. Trigger at ramp value 37. Required: o_trig_addr=5; readout 0..15 returns 33..48.
5. Sign extension and channel isolation. Chan 0 = 12'h800 with strobe; chan 3 strobing with 12'h7FF. Required: all words 16'hF800.
6. Control corner cases:
   - Reset asserted mid-POST: o_busy=0, o_done=0 next cycle; a new capture then succeeds.
   - i_start during POST: ignored.
   - i_rd_en while busy: o_rd_data=0.
